// File: rtl/clock_mode_ctrl.sv
// Timekeeping controller: seconds prescaler, hh:mm:ss counters and RUN/SET_HR/SET_MIN mode FSM.
// Time fields update on the prescaler terminal-count edge; blink qualifiers lag the prescaler by one cycle.
module clock_mode_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int PRE_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic [1:0] mode,
  output logic       blink_hours,
  output logic       blink_minutes
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(TICKS_PER_SEC / 2);

  mode_e            mode_q, mode_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [4:0]       hr_q, hr_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             blink_hr_q, blink_hr_d;
  logic             blink_min_q, blink_min_d;
  logic             pre_tc;

  assign pre_tc = (pre_q == PRE_LAST);

  always_comb begin
    mode_d      = mode_q;
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    tick_d      = 1'b0;
    pre_d       = pre_tc ? '0 : pre_q + PRE_W'(1);
    blink_hr_d  = (mode_q == SET_HR)  && (pre_q >= PRE_HALF);
    blink_min_d = (mode_q == SET_MIN) && (pre_q >= PRE_HALF);

    case (mode_q)
      RUN: begin
        // The tick still lands when mode_btn arrives on a terminal-count cycle.
        if (pre_tc) begin
          tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d = 6'd0;
              hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
        if (mode_btn) mode_d = SET_HR;
      end
      SET_HR: begin
        if (mode_btn)     mode_d = SET_MIN;
        else if (inc_btn) hr_d   = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
      end
      SET_MIN: begin
        // Leaving set mode restarts a full second so the first tick is a whole period away.
        if (mode_btn) begin
          mode_d = RUN;
          sec_d  = 6'd0;
          pre_d  = '0;
        end else if (inc_btn) begin
          min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: mode_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= RUN;
      pre_q       <= '0;
      hr_q        <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      tick_q      <= 1'b0;
      blink_hr_q  <= 1'b0;
      blink_min_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pre_q       <= pre_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
      blink_hr_q  <= blink_hr_d;
      blink_min_q <= blink_min_d;
    end
  end

  assign hours         = hr_q;
  assign minutes       = min_q;
  assign seconds       = sec_q;
  assign sec_tick      = tick_q;
  assign mode          = mode_q;
  assign blink_hours   = blink_hr_q;
  assign blink_minutes = blink_min_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with TICKS_PER_SEC=4.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_btn;
  logic       inc_btn;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic [1:0] mode;
  logic       blink_hours;
  logic       blink_minutes;

  clock_mode_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode_btn      (mode_btn),
    .inc_btn       (inc_btn),
    .hours         (hours),
    .minutes       (minutes),
    .seconds       (seconds),
    .sec_tick      (sec_tick),
    .mode          (mode),
    .blink_hours   (blink_hours),
    .blink_minutes (blink_minutes)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int pre_m = 0;
  int prev_pre = 0;
  int mode_m = 0;
  int ticks_seen = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hr"},  int'(hours),   h);
    chk({tag, "_min"}, int'(minutes), m);
    chk({tag, "_sec"}, int'(seconds), s);
  endtask

  // Advance one clock; pre_m/mode_m track the prescaler and mode the edge should produce.
  task automatic cyc();
    prev_pre = pre_m;
    if (mode_btn && mode_m == 2) pre_m = 0;
    else                         pre_m = (pre_m + 1) % 4;
    if (mode_btn) mode_m = (mode_m + 1) % 3;
    @(negedge clk);
  endtask

  task automatic pulse_mode();
    mode_btn = 1'b1;
    cyc();
    mode_btn = 1'b0;
  endtask

  task automatic pulse_inc();
    inc_btn = 1'b1;
    cyc();
    inc_btn = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (3) @(negedge clk);
    chk_time("rst", 0, 0, 0);
    chk("rst_tick", int'(sec_tick), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_blink_hr", int'(blink_hours), 0);
    chk("rst_blink_min", int'(blink_minutes), 0);

    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk("run_tick", int'(sec_tick), (c % 4 == 0) ? 1 : 0);
      chk("run_sec", int'(seconds), c / 4);
    end

    pulse_mode();
    chk("enter_hr_mode", int'(mode), 1);
    chk("enter_hr_sec", int'(seconds), 3);
    chk("enter_hr_tick", int'(sec_tick), 0);

    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("blink_hr", int'(blink_hours), (prev_pre >= 2) ? 1 : 0);
      chk("blink_min_in_hr", int'(blink_minutes), 0);
      chk("hr_frozen_tick", int'(sec_tick), 0);
      chk("hr_frozen_sec", int'(seconds), 3);
    end

    for (int i = 1; i <= 22; i++) begin
      pulse_inc();
      ticks_seen += int'(sec_tick);
    end
    chk("hr_set22", int'(hours), 22);
    chk("no_tick_set_hr", ticks_seen, 0);
    pulse_inc(); chk("hr_inc23", int'(hours), 23);
    pulse_inc(); chk("hr_wrap0", int'(hours), 0);
    pulse_inc(); chk("hr_inc1", int'(hours), 1);
    chk("hr_mode_hold", int'(mode), 1);

    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    cyc();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    chk("both_btn_mode", int'(mode), 2);
    chk("both_btn_hr", int'(hours), 1);

    for (int i = 1; i <= 59; i++) pulse_inc();
    chk("min_set59", int'(minutes), 59);
    pulse_inc(); chk_time("min_wrap", 1, 0, 3);
    pulse_inc(); chk_time("min_inc1", 1, 1, 3);

    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("blink_min", int'(blink_minutes), (prev_pre >= 2) ? 1 : 0);
      chk("blink_hr_in_min", int'(blink_hours), 0);
      chk("min_frozen_tick", int'(sec_tick), 0);
    end

    pulse_mode();
    chk("exit_mode", int'(mode), 0);
    chk_time("exit", 1, 1, 0);
    chk("exit_tick", int'(sec_tick), 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("exit_first_tick", int'(sec_tick), (c == 4) ? 1 : 0);
      chk("exit_first_sec", int'(seconds), (c == 4) ? 1 : 0);
    end

    pulse_mode();
    chk("carry_enter_mode", int'(mode), 1);
    chk("carry_sec_hold", int'(seconds), 1);
    repeat (22) pulse_inc();
    chk("carry_hr23", int'(hours), 23);
    pulse_mode();
    repeat (58) pulse_inc();
    chk("carry_min59", int'(minutes), 59);
    pulse_mode();
    chk("carry_run_mode", int'(mode), 0);
    repeat (58 * 4) cyc();
    chk_time("t_235958", 23, 59, 58);
    repeat (4) cyc();
    chk_time("t_235959", 23, 59, 59);
    chk("t_235959_tick", int'(sec_tick), 1);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      chk("pre_roll_tick", int'(sec_tick), 0);
      chk("pre_roll_hr", int'(hours), 23);
    end
    cyc();
    chk("roll_tick", int'(sec_tick), 1);
    chk_time("roll", 0, 0, 0);

    repeat (3) cyc();
    mode_btn = 1'b1;
    cyc();
    mode_btn = 1'b0;
    chk("tc_mode_tick", int'(sec_tick), 1);
    chk("tc_mode_sec", int'(seconds), 1);
    chk("tc_mode_mode", int'(mode), 1);

    pulse_mode();
    pulse_inc();
    chk_time("pre_reset", 0, 1, 1);
    chk("pre_reset_mode", int'(mode), 2);
    #2 reset = 1'b1;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_tick", int'(sec_tick), 0);
    chk("async_rst_blink_hr", int'(blink_hours), 0);
    chk("async_rst_blink_min", int'(blink_minutes), 0);
    @(negedge clk);
    reset  = 1'b0;
    pre_m  = 0;
    mode_m = 0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("post_rst_tick", int'(sec_tick), (c == 4) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
